mem_ap_burst: RTL and testbench

Parametrised memory access point that executes debug commands popped from the JTAG-side command FIFO as bus reads and writes. Results are pushed into the response FIFO. It sits between the JTAG async FIFO pair and the system bus peripheral port. Compared with the single-transfer AHB AP it adds:
- configurable data and address widths;
- byte-lane strobes derived from the address;
- address auto-increment after every beat;
- multi-beat read bursts;
- optional bus-error reporting.

---
 rtl/mem_ap_burst.sv | 175 +++++++++++++++++
 tb/tb_mem_ap_burst.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ap_burst.sv
// mem_ap_burst: debug memory access point. Pops commands from the JTAG-side
// command FIFO and performs TAR writes, single bus writes and multi-beat
// read bursts, pushing read data into the response FIFO.
// Optional feature macro: MEM_AP_ERR_RESP_EN (bus-error reporting, sticky
// error flag and DW+1-bit response words).
module mem_ap_burst #(
  parameter int DW     = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int CMD_W  = DW + LEN_W + 5
) (
  input  logic              AFT_CLK,
  input  logic              nRST,
  input  logic [CMD_W-1:0]  cmd_rdata,
  input  logic              cmd_rempty,
  output logic              cmd_rinc,
`ifdef MEM_AP_ERR_RESP_EN
  output logic [DW:0]       rsp_wdata,
`else
  output logic [DW-1:0]     rsp_wdata,
`endif
  input  logic              rsp_wfull,
  output logic              rsp_winc,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DW-1:0]     bus_wdata,
  output logic [DW/8-1:0]   bus_strobe,
  output logic              bus_ren,
  output logic              bus_wen,
  input  logic [DW-1:0]     bus_rdata,
  input  logic              bus_request_stall,
  input  logic              bus_error,
  output logic              busy,
  output logic              sticky_err
);

  localparam int unsigned NB       = DW / 8;
  localparam int unsigned OB       = $clog2(NB);
  localparam logic [1:0]  MAX_SIZE = 2'(OB);
`ifdef MEM_AP_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0]    payload;
    logic [LEN_W-1:0] len;
    logic             reg_sel;
    logic [1:0]       size;
    logic             incr;
    logic             rw;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WRITE, READ, PUSH} state_t;

  state_t             state;
  cmd_t               cmd_in;
  cmd_t               cmd_reg;
  logic [ADDR_W-1:0]  tar;
  logic [DW-1:0]      rsp_reg;
  logic               rsp_err;
  logic [LEN_W-1:0]   beats_left;
  logic               sticky_q;
  logic               drop;
  logic [1:0]         eff_size;
  logic [ADDR_W-1:0]  tar_step;

  assign cmd_in = cmd_rdata;

  // Clamp oversized transfers to the full bus width and derive the TAR step.
  always_comb begin
    eff_size = (cmd_reg.size > MAX_SIZE) ? MAX_SIZE : cmd_reg.size;
    tar_step = ADDR_W'(1) << eff_size;
  end

  // Byte lanes: every lane in the same size-aligned group as TAR is enabled.
  always_comb begin
    bus_strobe = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      bus_strobe[i] = ((i >> eff_size) == (32'(tar[OB-1:0]) >> eff_size));
    end
  end

  // Command sequencer: state, TAR, latched command and response capture.
  always_ff @(posedge AFT_CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      tar        <= '0;
      cmd_reg    <= '0;
      rsp_reg    <= '0;
      rsp_err    <= 1'b0;
      beats_left <= '0;
      sticky_q   <= 1'b0;
      drop       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!cmd_rempty) begin
            cmd_reg <= cmd_in;
            if (!cmd_in.reg_sel) begin
              tar      <= cmd_in.payload[ADDR_W-1:0];
              sticky_q <= 1'b0;
            end else if (cmd_in.rw) begin
              // A latched error swallows writes with no bus activity.
              if (!sticky_q) state <= WRITE;
            end else begin
              beats_left <= cmd_in.len;
              if (sticky_q) begin
                // Discarded read still answers len+1 error words.
                rsp_reg <= '0;
                rsp_err <= 1'b1;
                drop    <= 1'b1;
                state   <= PUSH;
              end else begin
                drop  <= 1'b0;
                state <= READ;
              end
            end
          end
        end
        WRITE: begin
          if (!bus_request_stall) begin
            if (ERR_EN && bus_error) sticky_q <= 1'b1;
            if (cmd_reg.incr) tar <= tar + tar_step;
            state <= IDLE;
          end
        end
        READ: begin
          if (!bus_request_stall) begin
            rsp_reg <= bus_rdata;
            rsp_err <= ERR_EN && bus_error;
            if (ERR_EN && bus_error) sticky_q <= 1'b1;
            if (cmd_reg.incr) tar <= tar + tar_step;
            state <= PUSH;
          end
        end
        PUSH: begin
          if (!rsp_wfull) begin
            if (beats_left != '0) begin
              beats_left <= beats_left - 1'b1;
              state      <= drop ? PUSH : READ;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake strobes decoded from the current state.
  always_comb begin
    cmd_rinc = nRST && (state == IDLE) && !cmd_rempty;
    rsp_winc = (state == PUSH) && !rsp_wfull;
    bus_wen  = (state == WRITE);
    bus_ren  = (state == READ);
    busy     = (state != IDLE);
  end

  assign bus_addr   = tar;
  assign bus_wdata  = cmd_reg.payload;
  assign sticky_err = sticky_q;

`ifdef MEM_AP_ERR_RESP_EN
  assign rsp_wdata = {rsp_err, rsp_reg};
  logic unused_bits;
  assign unused_bits = ^{cmd_reg.len, cmd_reg.reg_sel, cmd_reg.rw};
`else
  assign rsp_wdata = rsp_reg;
  logic unused_bits;
  assign unused_bits = ^{cmd_reg.len, cmd_reg.reg_sel, cmd_reg.rw, rsp_err};
`endif

endmodule

// File: tb/tb_mem_ap_burst.sv
// Directed bench for mem_ap_burst (DW=32, ADDR_W=32, LEN_W=4).
module tb_mem_ap_burst;

`ifdef MEM_AP_ERR_RESP_EN
  localparam int RW = 33;
`else
  localparam int RW = 32;
`endif

  logic          clk = 1'b0;
  logic          nrst;
  logic [40:0]   cmd_rdata;
  logic          cmd_rempty;
  logic          cmd_rinc;
  logic [RW-1:0] rsp_wdata;
  logic          rsp_wfull;
  logic          rsp_winc;
  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic [3:0]    bus_strobe;
  logic          bus_ren;
  logic          bus_wen;
  logic [31:0]   bus_rdata;
  logic          bus_request_stall;
  logic          bus_error;
  logic          busy;
  logic          sticky_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_ap_burst #(.DW(32), .ADDR_W(32), .LEN_W(4)) dut (
    .AFT_CLK(clk), .nRST(nrst),
    .cmd_rdata(cmd_rdata), .cmd_rempty(cmd_rempty), .cmd_rinc(cmd_rinc),
    .rsp_wdata(rsp_wdata), .rsp_wfull(rsp_wfull), .rsp_winc(rsp_winc),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_strobe(bus_strobe),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_rdata(bus_rdata),
    .bus_request_stall(bus_request_stall), .bus_error(bus_error),
    .busy(busy), .sticky_err(sticky_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [40:0] mk(input logic [31:0] pl, input logic [3:0] len,
                                     input logic rs, input logic [1:0] sz,
                                     input logic inc, input logic rw);
    return {pl, len, rs, sz, inc, rw};
  endfunction

  // Present one command at a negedge, expect the pop, empty the FIFO after the edge.
  task automatic pop(input logic [40:0] c);
    @(negedge clk);
    cmd_rdata  = c;
    cmd_rempty = 1'b0;
    #1 chk("pop_rinc", cmd_rinc, 1);
    @(posedge clk);
    #1 cmd_rempty = 1'b1;
  endtask

  initial begin
    logic [15:0] sb;
    sb = 16'h4218;
    nrst = 1'b0; cmd_rdata = '0; cmd_rempty = 1'b1; rsp_wfull = 1'b0;
    bus_rdata = '0; bus_request_stall = 1'b0; bus_error = 1'b0;

    // Reset values
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_ren", bus_ren, 0);
    chk("rst_wen", bus_wen, 0);
    chk("rst_winc", rsp_winc, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_strobe", bus_strobe, 4'h1);
    chk("rst_rsp", rsp_wdata, 0);
    chk("rst_sticky", sticky_err, 0);
    cmd_rempty = 1'b0;
    #1 chk("rst_rinc_gated", cmd_rinc, 0);
    cmd_rempty = 1'b1;
    @(negedge clk); nrst = 1'b1;

    // TAR write then single word write with increment
    pop(mk(32'h1000, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    @(negedge clk);
    chk("tar_busy", busy, 0);
    chk("tar_addr", bus_addr, 32'h1000);
    pop(mk(32'hDEADBEEF, 4'd0, 1'b1, 2'd2, 1'b1, 1'b1));
    @(negedge clk);
    chk("wr_wen", bus_wen, 1);
    chk("wr_ren", bus_ren, 0);
    chk("wr_addr", bus_addr, 32'h1000);
    chk("wr_strobe", bus_strobe, 4'hF);
    chk("wr_wdata", bus_wdata, 32'hDEADBEEF);
    chk("wr_busy", busy, 1);
    @(negedge clk);
    chk("wr_done_wen", bus_wen, 0);
    chk("wr_done_busy", busy, 0);
    chk("wr_tar_inc", bus_addr, 32'h1004);

    // Stalled write: six cycles of stable wen/addr, one completion
    bus_request_stall = 1'b1;
    pop(mk(32'h12345678, 4'd0, 1'b1, 2'd2, 1'b1, 1'b1));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("stall_wen", bus_wen, 1);
      chk("stall_addr", bus_addr, 32'h1004);
      chk("stall_busy", busy, 1);
      if (k == 5) bus_request_stall = 1'b0;
    end
    @(negedge clk);
    chk("stall_done_wen", bus_wen, 0);
    chk("stall_done_addr", bus_addr, 32'h1008);

    // Byte burst from misaligned 0x2003, four beats
    pop(mk(32'h2003, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    pop(mk(32'h0, 4'd3, 1'b1, 2'd0, 1'b1, 1'b0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bb_ren", bus_ren, 1);
      chk("bb_addr", bus_addr, 32'h2003 + k);
      chk("bb_strobe", bus_strobe, sb[k*4 +: 4]);
      bus_rdata = 32'hA0 + k;
      @(negedge clk);
      chk("bb_winc", rsp_winc, 1);
      chk("bb_ren_off", bus_ren, 0);
      chk("bb_data", rsp_wdata, 32'hA0 + k);
    end
    @(negedge clk);
    chk("bb_idle", busy, 0);
    chk("bb_tar", bus_addr, 32'h2007);

    // Response FIFO full for 10 cycles during a 2-beat read
    pop(mk(32'h3000, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    pop(mk(32'h0, 4'd1, 1'b1, 2'd2, 1'b1, 1'b0));
    @(negedge clk);
    chk("full_ren0", bus_ren, 1);
    chk("full_addr0", bus_addr, 32'h3000);
    bus_rdata = 32'h11111111;
    rsp_wfull = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("full_winc", rsp_winc, 0);
      chk("full_ren", bus_ren, 0);
      chk("full_busy", busy, 1);
    end
    rsp_wfull = 1'b0;
    #1 chk("full_winc0", rsp_winc, 1);
    chk("full_data0", rsp_wdata, 32'h11111111);
    @(negedge clk);
    chk("full_ren1", bus_ren, 1);
    chk("full_addr1", bus_addr, 32'h3004);
    bus_rdata = 32'h22222222;
    @(negedge clk);
    chk("full_winc1", rsp_winc, 1);
    chk("full_data1", rsp_wdata, 32'h22222222);
    @(negedge clk);
    chk("full_idle", busy, 0);

    // Address wrap at the top of the address space
    pop(mk(32'hFFFFFFFC, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    pop(mk(32'h0, 4'd1, 1'b1, 2'd2, 1'b1, 1'b0));
    @(negedge clk);
    chk("wrap_addr0", bus_addr, 32'hFFFFFFFC);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_ren1", bus_ren, 1);
    chk("wrap_addr1", bus_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_tar", bus_addr, 32'h4);

    // Oversized size clamps to a word; misaligned half, no increment
    pop(mk(32'h4002, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    pop(mk(32'h55, 4'd0, 1'b1, 2'd3, 1'b1, 1'b1));
    @(negedge clk);
    chk("clamp_strobe", bus_strobe, 4'hF);
    @(negedge clk);
    chk("clamp_tar", bus_addr, 32'h4006);
    pop(mk(32'h66, 4'd0, 1'b1, 2'd1, 1'b0, 1'b1));
    @(negedge clk);
    chk("half_strobe", bus_strobe, 4'hC);
    @(negedge clk);
    chk("half_tar", bus_addr, 32'h4006);

    // Reset in the middle of a burst aborts immediately
    pop(mk(32'h5000, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    pop(mk(32'h0, 4'd3, 1'b1, 2'd2, 1'b1, 1'b0));
    @(negedge clk);
    rsp_wfull = 1'b1;
    @(negedge clk);
    nrst = 1'b0;
    #1 chk("abort_winc", rsp_winc, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", bus_addr, 0);
    rsp_wfull = 1'b0;
    @(negedge clk);
    chk("abort_winc_hold", rsp_winc, 0);
    nrst = 1'b1;
    @(negedge clk);
    chk("abort_idle", busy, 0);

    // Bus error on a write
    pop(mk(32'h6000, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    pop(mk(32'h77, 4'd0, 1'b1, 2'd2, 1'b1, 1'b1));
    @(negedge clk);
    chk("err_wen", bus_wen, 1);
    bus_error = 1'b1;
    @(posedge clk);
    #1 bus_error = 1'b0;
`ifdef MEM_AP_ERR_RESP_EN
    chk("err_sticky", sticky_err, 1);
    pop(mk(32'h0, 4'd1, 1'b1, 2'd2, 1'b1, 1'b0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("err_ren", bus_ren, 0);
      chk("err_winc", rsp_winc, 1);
      chk("err_data", rsp_wdata, 33'h1_0000_0000);
    end
    @(negedge clk);
    chk("err_idle", busy, 0);
    chk("err_tar", bus_addr, 32'h6004);
    pop(mk(32'h7000, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    @(negedge clk);
    chk("err_clear", sticky_err, 0);
`else
    chk("noerr_sticky", sticky_err, 0);
    pop(mk(32'h0, 4'd0, 1'b1, 2'd2, 1'b1, 1'b0));
    @(negedge clk);
    chk("noerr_ren", bus_ren, 1);
    bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("noerr_data", rsp_wdata, 32'hCAFEF00D);
    @(negedge clk);
    chk("noerr_tar", bus_addr, 32'h6008);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
